updown_mod_counter: RTL and testbench

//  Parametrised up/down counter with programmable bounds [MIN_VAL..MAX_VAL].

---
 rtl/updown_mod_counter_pkg.sv | 19 +
 rtl/udc_next_val.sv | 51 +++++
 rtl/updown_mod_counter.sv | 87 ++++++++
 tb/tb_updown_mod_counter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/updown_mod_counter_pkg.sv
// Shared types and helpers for the up/down modulo counter.
// Direction encodings and the load clamp used by RTL and bench.
package updown_mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Pin value into [lo..hi]
  function automatic int unsigned clamp_val(
    input int unsigned value,
    input int unsigned lo,
    input int unsigned hi
  );
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/udc_next_val.sv
// Next-count / terminal-count logic for updown_mod_counter.
// Ports: count_i, mode_i in; next_o, tc_o out (combinational).
module udc_next_val
  import updown_mod_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 7,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             tc_o
);

  localparam logic [WIDTH:0] LO = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] HI = (WIDTH+1)'(MAX_VAL);
  localparam bit             SAT = (SATURATE != 0);

  // One extra bit so the +1 at 2**WIDTH-1 cannot alias
  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] step;

  assign cnt_x = {1'b0, count_i};

  always_comb begin
    step = cnt_x;
    tc_o = 1'b0;
    if (mode_i == DIR_UP) begin
      if (cnt_x >= HI) begin
        step = SAT ? HI : LO;
        tc_o = 1'b1;
      end else begin
        step = cnt_x + 1'b1;
      end
    end else begin
      if (cnt_x <= LO) begin
        step = SAT ? LO : HI;
        tc_o = 1'b1;
      end else begin
        step = cnt_x - 1'b1;
      end
    end
    next_o = step[WIDTH-1:0];
  end

  logic unused_step_msb;
  assign unused_step_msb = step[WIDTH];

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter over [MIN_VAL..MAX_VAL], wrap or saturate, tc pulse.
// Ports: clk rst en mode load load_val -> data_out tc at_max at_min.
// Macro UDC_LOAD_EN enables the clamped parallel load.
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 7,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  generate
    if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL &&
          MAX_VAL <= (2**WIDTH) - 1)) begin : g_bad
      $error("updown_mod_counter: bad bounds");
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] nxt_cnt;
  logic             nxt_tc;

  udc_next_val #(
    .WIDTH    (WIDTH),
    .MIN_VAL  (MIN_VAL),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_next (
    .count_i (count_q),
    .mode_i  (mode),
    .next_o  (nxt_cnt),
    .tc_o    (nxt_tc)
  );

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
`ifdef UDC_LOAD_EN
    if (load) begin
      count_d = WIDTH'(clamp_val(32'(load_val),
                                 MIN_VAL, MAX_VAL));
    end else if (en) begin
      count_d = nxt_cnt;
      tc_d    = nxt_tc;
    end
`else
    if (en) begin
      count_d = nxt_cnt;
      tc_d    = nxt_tc;
    end
`endif
  end

`ifndef UDC_LOAD_EN
  logic unused_load;
  assign unused_load = ^{load, load_val};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= WIDTH'(MIN_VAL);
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign data_out = count_q;
  assign tc       = tc_q;
  assign at_max   = (count_q == WIDTH'(MAX_VAL));
  assign at_min   = (count_q == WIDTH'(MIN_VAL));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: wrap, saturate and MIN_VAL=2 copies.
// Scoreboard queue of expected outputs, checked 1ns after each edge.
module tb_updown_mod_counter;
  import updown_mod_counter_pkg::*;

`ifdef UDC_LOAD_EN
  localparam bit LOAD_ON = 1'b1;
`else
  localparam bit LOAD_ON = 1'b0;
`endif
  localparam int HI = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode, load;
  logic [3:0] load_val;
  logic [3:0] dq  [3];
  logic       tcv [3];
  logic       amx [3];
  logic       amn [3];

  updown_mod_counter #(.SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .load(load), .load_val(load_val),
    .data_out(dq[0]), .tc(tcv[0]),
    .at_max(amx[0]), .at_min(amn[0])
  );

  updown_mod_counter #(.SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .load(load), .load_val(load_val),
    .data_out(dq[1]), .tc(tcv[1]),
    .at_max(amx[1]), .at_min(amn[1])
  );

  updown_mod_counter #(.MIN_VAL(2)) u_min2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .load(load), .load_val(load_val),
    .data_out(dq[2]), .tc(tcv[2]),
    .at_max(amx[2]), .at_min(amn[2])
  );

  typedef struct packed {
    logic [2:0][3:0] c;
    logic [2:0]      t;
  } exp_t;

  exp_t sb[$];
  int   mc    [3];
  int   lo_a  [3] = '{0, 0, 2};
  int   sat_a [3] = '{0, 1, 0};
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit m,
                     input bit l, input logic [3:0] lv);
    exp_t x;
    rst = r; en = e; mode = m; load = l; load_val = lv;
    for (int k = 0; k < 3; k++) begin
      int c;
      bit t;
      c = mc[k];
      t = 1'b0;
      if (r) begin
        c = lo_a[k];
      end else if (l && LOAD_ON) begin
        c = int'(clamp_val(int'(lv), lo_a[k], HI));
      end else if (e) begin
        if (m == DIR_UP) begin
          if (c == HI) begin
            c = sat_a[k] != 0 ? HI : lo_a[k];
            t = 1'b1;
          end else c = c + 1;
        end else begin
          if (c == lo_a[k]) begin
            c = sat_a[k] != 0 ? lo_a[k] : HI;
            t = 1'b1;
          end else c = c - 1;
        end
      end
      mc[k]  = c;
      x.c[k] = 4'(c);
      x.t[k] = t;
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("d%0d_cnt", k), 32'(dq[k]), 32'(x.c[k]));
      check($sformatf("d%0d_tc", k), 32'(tcv[k]), 32'(x.t[k]));
      check($sformatf("d%0d_max", k), 32'(amx[k]),
            32'(x.c[k] == 4'(HI)));
      check($sformatf("d%0d_min", k), 32'(amn[k]),
            32'(x.c[k] == 4'(lo_a[k])));
    end
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 4'd0);
    cyc(1, 0, 0, 0, 4'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0;
    load = 1'b0; load_val = '0;
    // T1 up wrap
    do_reset();
    for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 4'd0);
    // T2 down wrap
    do_reset();
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, 4'd0);
    // T3 run into the upper bound, then step down
    do_reset();
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 4'd0);
    cyc(0, 1, 0, 0, 4'd0);
    // T4 loads (ignored without the load feature)
    do_reset();
    cyc(0, 1, 1, 1, 4'd5);
    cyc(0, 1, 1, 1, 4'd12);
    cyc(0, 1, 0, 1, 4'd0);
    cyc(0, 1, 1, 0, 4'd0);
    cyc(0, 0, 1, 1, 4'd3);
    cyc(0, 1, 0, 1, 4'd15);
    cyc(1, 1, 1, 1, 4'd6);
    // T5 reset beats counting
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 4'd0);
    cyc(1, 1, 1, 0, 4'd0);
    // T6 hold with mode toggling, then alternate
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 4'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, i[0], 0, 4'd0);
    for (int i = 0; i < 4; i++) cyc(0, 1, ~i[0], 0, 4'd0);
    // random mix
    do_reset();
    for (int i = 0; i < 80; i++) begin
      cyc($urandom_range(0, 19) == 0,
          $urandom_range(0, 3) != 0,
          1'($urandom_range(0, 1)),
          $urandom_range(0, 4) == 0,
          4'($urandom_range(0, 15)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
